// File: rtl/hazard_detect_unit.sv
// Hazard controller for the 5-stage core: load-use stall, branch/jump squash, memory-wait freeze, event counters.
// Controls are combinational from state and inputs (zero latency); counters update one cycle after the event; mem_wait freezes everything.
module hazard_detect_unit #(
    parameter int REG_W      = 3,
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic ctrl_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTL_NORM   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, ctrl_flush: 1'b0, pipe_hold: 1'b0};
    localparam ctrl_t CTL_RST    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, ctrl_flush: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTL_HOLD   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, ctrl_flush: 1'b0, pipe_hold: 1'b1};
    localparam ctrl_t CTL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, ctrl_flush: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, ctrl_flush: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTL_JUMP   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, ctrl_flush: 1'b0, pipe_hold: 1'b0};

    localparam logic [2:0]       REM_RELOAD = 3'(BR_PENALTY - 1);
    localparam bit               MULTI_CYC  = (BR_PENALTY > 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [2:0]       rem, rem_nxt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_evt, flush_evt;
    logic             lu_haz;
    ctrl_t            ctl;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        lu_haz = idex_memRead && (idex_dst != '0) &&
                 ((id_uses_rs && (id_rs == idex_dst)) ||
                  (id_uses_rt && (id_rt == idex_dst)));
    end

    always_comb begin
        ctl       = CTL_NORM;
        state_nxt = state;
        rem_nxt   = rem;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        if (rst) begin
            ctl = CTL_RST;
        end else if (mem_wait) begin
            ctl = CTL_HOLD;
        end else if ((state == FLUSH) || branch_taken) begin
            // Wrong-path cycles: hazards and jumps in ID are discarded anyway.
            ctl = CTL_SQUASH;
            if (branch_taken) begin
                flush_evt = 1'b1;
                rem_nxt   = REM_RELOAD;
                state_nxt = MULTI_CYC ? FLUSH : RUN;
            end else begin
                rem_nxt   = (rem == 3'd0) ? 3'd0 : rem - 3'd1;
                state_nxt = (rem <= 3'd1) ? RUN : FLUSH;
            end
        end else if (lu_haz) begin
            ctl       = CTL_STALL;
            stall_evt = 1'b1;
        end else if (id_jump) begin
            ctl = CTL_JUMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            rem         <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stall_evt && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_evt && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign pc_write   = ctl.pc_write;
    assign ifid_write = ctl.ifid_write;
    assign ifid_flush = ctl.ifid_flush;
    assign ctrl_flush = ctl.ctrl_flush;
    assign pipe_hold  = ctl.pipe_hold;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Pipeline hazard controller for the 5-stage RISC core. It decides each cycle whether the ID-stage control word is replaced with a bubble (drives `ctrl_flush`, the select of the control flush mux feeding ID/EX). It also drives PC / IF/ID write enables, the IF/ID squash, and a whole-pipeline hold. It detects load-use hazards, sequences the multi-cycle wrong-path squash after a taken branch, squashes after jumps, freezes on data-memory wait, and keeps saturating event counters.

## Interface
Parameters:
- `REG_W`, 3, register-address width.
- `BR_PENALTY`, 2, number of non-wait cycles squashed per taken branch (legal range 1..7).
- `CNT_W`, 16, width of the event counters.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_rs` input REG_W: rs field of instruction in ID.
- `id_rt` input REG_W: rt field of instruction in ID.
- `id_uses_rs` input 1: ID instruction reads rs.
- `id_uses_rt` input 1: ID instruction reads rt.
- `id_jump` input 1: ID instruction is a jump (target resolved in ID).
- `idex_memRead` input 1: instruction in EX is a load.
- `idex_dst` input REG_W: destination register of instruction in EX.
- `branch_taken` input 1: branch resolved taken in MEM; held by the pipeline while frozen.
- `mem_wait` input 1: data memory not ready; the whole pipeline must hold.
- `pc_write` output 1: PC load enable.
- `ifid_write` output 1: IF/ID load enable.
- `ifid_flush` output 1: IF/ID loads a NOP.
- `ctrl_flush` output 1: control flush mux select (1 = zero control into ID/EX).
- `pipe_hold` output 1: ID/EX, EX/MEM, MEM/WB hold.
- `stall_cnt` output CNT_W: load-use stall cycles, saturating.
- `flush_cnt` output CNT_W: accepted taken-branch events, saturating.

## Operation
- State: `RUN`, `FLUSH`. Remaining-flush counter `rem` is 3 bits wide.
- `lu_haz` = `idex_memRead` & (`idex_dst` != 0) & ((`id_uses_rs` & `id_rs`==`idex_dst`) | (`id_uses_rt` & `id_rt`==`idex_dst`)).
- Precedence per cycle, highest first: reset, `mem_wait`, branch/`FLUSH`, `lu_haz`, `id_jump`, normal.
- Reset (while `rst`=1):
  - `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `ctrl_flush`=1, `pipe_hold`=0.
  - Next state `RUN`, `rem`=0, both counters 0.
- `mem_wait`=1:
  - `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `ctrl_flush`=0, `pipe_hold`=1.
  - State, `rem` and counters are frozen.
  - `branch_taken` is not accepted in wait cycles.
- Taken branch (`RUN`, `branch_taken`=1, no wait):
  - `ifid_flush`=1, `ctrl_flush`=1, `pc_write`=1, `ifid_write`=1.
  - `flush_cnt`++.
  - If `BR_PENALTY`>1: go to `FLUSH` with `rem`=`BR_PENALTY`-1; else stay in `RUN`.
- `FLUSH`, no wait:
  - Same outputs as a taken branch; `rem`--.
  - Return to `RUN` when `rem` reaches 0.
  - `lu_haz` and `id_jump` are ignored (wrong path).
  - `branch_taken`=1 here reloads `rem`=`BR_PENALTY`-1 and increments `flush_cnt`.
- `RUN`, `lu_haz`:
  - `pc_write`=0, `ifid_write`=0, `ctrl_flush`=1, `ifid_flush`=0.
  - `stall_cnt`++.
- `RUN`, `id_jump` (no `lu_haz`): `ifid_flush`=1, `ctrl_flush`=0, enables 1.
- Normal: `pc_write`=1, `ifid_write`=1, all flush/hold signals 0.
- Counters saturate at all-ones and do not wrap.

## Timing
- All outputs except the counters are combinational from state, `rem` and the current inputs: zero-cycle latency from hazard to control.
- State, `rem` and counters update on the rising edge; counter values are visible the cycle after the event.
- A load-use hazard produces exactly one bubble: after the stall, ID/EX holds zero control, so `lu_haz` drops.
- A taken branch yields exactly `BR_PENALTY` squash cycles, excluding `mem_wait` cycles, which extend the sequence without consuming it.
- `rst` asserted mid-`FLUSH` aborts the sequence; the first post-reset cycle is `RUN`.

## Test plan
- Load `r3` in EX (`idex_memRead`=1, `idex_dst`=3), ID with `id_rs`=3, `id_uses_rs`=1 → same cycle `pc_write`=0, `ifid_write`=0, `ctrl_flush`=1; next cycle with `idex_memRead`=0 → normal; `stall_cnt`=1.
- Load with `idex_dst`=0 and matching `id_rs`=0 → no stall; same hazard with `id_uses_rs`=0 → no stall.
- `BR_PENALTY`=2, `branch_taken` one cycle → `ifid_flush`=`ctrl_flush`=1 for exactly 2 cycles, then `RUN`; `flush_cnt`=1. With `lu_haz` asserted during the second cycle → no stall, `stall_cnt` unchanged.
- `branch_taken` cycle followed by 3 `mem_wait` cycles, then wait released → during wait `pipe_hold`=1 and flushes 0; second flush cycle occurs after the release; total flush cycles = 2.
- `id_jump`=1 together with `lu_haz` → stall first (`ifid_flush`=0); next cycle jump → `ifid_flush`=1, `ctrl_flush`=0.
- `rst` mid-`FLUSH` → reset outputs and zero counters; first cycle after `rst` drops is normal `RUN`. Preload a counter to all-ones (force) plus one event → holds all-ones.
